lsu_ctrl: RTL
=============

Name: lsu_ctrl

Overview:
Load/store unit directly downstream of the RV32I execute-stage ALU. It takes the ALU result as the effective address, plus rs2 and funct3. It drives a single-outstanding request/grant/response data-memory port, then returns aligned, sign/zero-extended load data to writeback. It also detects misaligned and illegal accesses and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 255, cycles allowed in REQ or WAIT before a timeout error; 0 disables timeout
CNT_W, 8, width of timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  execute stage presents a memory op
req_ready  out  1  LSU can accept (IDLE only)
is_store  in  1  1 = store, 0 = load
funct3  in  3  RV32I width/sign (LB0 LH1 LW2 LBU4 LHU5; SB0 SH1 SW2)
addr  in  32  effective address (ALU result)
wdata  in  32  store data (rs2)
rd_in  in  5  load destination tag
mem_req  out  1  memory request
mem_we  out  1  write enable
mem_addr  out  32  word address, bits[1:0]=00
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid this cycle
mem_rdata  in  32  read word
resp_valid  out  1  one-cycle completion pulse
resp_is_load  out  1  completed op was a load
resp_rd  out  5  latched rd_in (0 for stores)
resp_data  out  32  extended load data (0 for stores/errors)
resp_err  out  1  op failed
err_cause  out  2  01 misaligned, 10 illegal funct3, 11 timeout, 00 none
err_addr  out  32  full byte address of the failed op

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE. All outputs are registered, except req_ready = (state==IDLE).
- Reset (rst_n low at an edge): state goes to IDLE. Every output is 0 while rst_n is low, including req_ready. req_ready is 1 from the first cycle after release.
- Reset mid-op: abandon the transaction. mem_req is 0 after the edge and no resp_valid is produced.
- Accept: req_valid && req_ready at edge T latches is_store, funct3, addr, wdata, rd_in.
  - Illegal funct3 (load 3/6/7, store >=3) goes to DONE with err 10.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0) goes to DONE with err 01.
  - Illegal takes priority over misaligned. Neither case issues a memory access.
  - Otherwise the FSM goes to REQ.
- REQ: mem_req=1, mem_we=is_store, mem_addr={addr[31:2],2'b00}. mem_be, mem_wdata and mem_addr stay stable until grant.
  - mem_be: SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW 1111.
  - mem_wdata: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
  - mem_gnt sampled 1: store goes to DONE; load goes to WAIT. mem_req is 0 from the next cycle.
- WAIT: on mem_rvalid, shift mem_rdata right by 8*addr[1:0] and extend.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
  - Latch the result into resp_data and go to DONE.
- mem_gnt outside REQ and mem_rvalid outside WAIT are ignored. mem_rvalid in the same cycle as mem_gnt is ignored.
- Timeout: counter clears on entry to REQ and to WAIT and increments each cycle in that state.
  - If it reaches TIMEOUT_CYCLES without gnt/rvalid: go to DONE with err 11 and drop mem_req.
- DONE (exactly one cycle): resp_valid=1 with resp_* and err_* valid, then go to IDLE.
  - On error, resp_data=0 and err_addr=latched addr; otherwise err_addr=0.
- Latency:
  - Store: accept T, mem_req T+1; gnt at T+1 gives resp T+2; req_ready again T+3.
  - Load: with gnt at T+1 and rvalid at T+2, resp at T+3.
  - Error at accept: resp T+1.
- One op in flight at a time. req_valid is ignored while req_ready=0.

Test Plan:
- SW addr=0x1000, wdata=0xDEADBEEF, gnt on first REQ cycle -> mem_addr=0x1000, be=1111, wdata=0xDEADBEEF, we=1; resp_valid 2 cycles after accept, resp_err=0.
- SB addr=0x1003, wdata=0x000000A5 -> be=1000, mem_wdata=0xA5A5A5A5; SH addr=0x1002 wdata=0x1234 -> be=1100, mem_wdata=0x12341234.
- Loads from word 0x80F17F01:
  - LB at offset 3 -> 0xFFFFFF80.
  - LBU at offset 3 -> 0x00000080.
  - LH at offset 2 -> 0xFFFF80F1.
  - LHU at offset 0 -> 0x00007F01.
  - LW -> 0x80F17F01.
  - resp_rd equals rd_in in each case.
- LW addr=0x1002 -> no mem_req, resp next cycle with err_cause=01, err_addr=0x1002. Load funct3=3 -> err_cause=10.
- TIMEOUT_CYCLES=4, gnt never asserted -> mem_req high 4 cycles, then resp_err=1, err_cause=11, FSM back to IDLE. Repeat with gnt but no rvalid -> same.
- Load in WAIT, rst_n low one cycle -> no resp_valid, mem_req=0, req_ready=1 the cycle after release; next op completes normally.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store unit with single-outstanding memory port, alignment/illegal checks and bus timeout
module lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic        resp_is_load,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [1:0]  err_cause,
  output logic [31:0] err_addr
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT_CYCLES - 1);
  state_t state;
  logic st;
  logic [2:0] f3;
  logic [31:0] a;
  logic [4:0] rd;
  logic [CNT_W-1:0] cnt;
  logic ill, mis, tmo;
  logic [3:0] be;
  logic [31:0] wrep, sh, ld;
  assign req_ready = rst_n && state == IDLE;
  always_comb begin
    ill = is_store ? funct3 >= 3'd3 : funct3 == 3'd3 || funct3[2:1] == 2'b11;
    mis = funct3[1:0] == 2'd1 ? addr[0] : funct3[1:0] == 2'd2 ? addr[1:0] != 2'd0 : 1'b0;
    be = funct3[1:0] == 2'd0 ? 4'b0001 << addr[1:0] : funct3[1:0] == 2'd1 ? 4'b0011 << addr[1:0] : 4'b1111;
    wrep = funct3[1:0] == 2'd0 ? {4{wdata[7:0]}} : funct3[1:0] == 2'd1 ? {2{wdata[15:0]}} : wdata;
    sh = mem_rdata >> {a[1:0], 3'b000};
    ld = f3 == 3'd0 ? {{24{sh[7]}}, sh[7:0]} :
         f3 == 3'd1 ? {{16{sh[15]}}, sh[15:0]} :
         f3 == 3'd4 ? {24'd0, sh[7:0]} :
         f3 == 3'd5 ? {16'd0, sh[15:0]} : sh;
    tmo = TIMEOUT_CYCLES != 0 && cnt == TMAX;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      st <= 1'b0;
      f3 <= 3'd0;
      a <= 32'd0;
      rd <= 5'd0;
      cnt <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= 32'd0;
      mem_be <= 4'd0;
      mem_wdata <= 32'd0;
      resp_valid <= 1'b0;
      resp_is_load <= 1'b0;
      resp_rd <= 5'd0;
      resp_data <= 32'd0;
      resp_err <= 1'b0;
      err_cause <= 2'd0;
      err_addr <= 32'd0;
    end else begin
      resp_valid <= 1'b0;
      resp_is_load <= 1'b0;
      resp_rd <= 5'd0;
      resp_data <= 32'd0;
      resp_err <= 1'b0;
      err_cause <= 2'd0;
      err_addr <= 32'd0;
      case (state)
        IDLE: if (req_valid) begin
          st <= is_store;
          f3 <= funct3;
          a <= addr;
          rd <= rd_in;
          cnt <= '0;
          if (ill || mis) begin
            state <= DONE;
            resp_valid <= 1'b1;
            resp_is_load <= !is_store;
            resp_rd <= is_store ? 5'd0 : rd_in;
            resp_err <= 1'b1;
            err_cause <= ill ? 2'b10 : 2'b01;
            err_addr <= addr;
          end else begin
            state <= REQ;
            mem_req <= 1'b1;
            mem_we <= is_store;
            mem_addr <= {addr[31:2], 2'b00};
            mem_be <= be;
            mem_wdata <= wrep;
          end
        end
        REQ: if (mem_gnt || tmo) begin
          mem_req <= 1'b0;
          mem_we <= 1'b0;
          cnt <= '0;
          state <= mem_gnt && !st ? WAIT : DONE;
          if (!mem_gnt || st) begin
            resp_valid <= 1'b1;
            resp_is_load <= !st;
            resp_rd <= st ? 5'd0 : rd;
            resp_err <= !mem_gnt;
            err_cause <= mem_gnt ? 2'b00 : 2'b11;
            err_addr <= mem_gnt ? 32'd0 : a;
          end
        end else cnt <= cnt + 1'b1;
        WAIT: if (mem_rvalid || tmo) begin
          state <= DONE;
          resp_valid <= 1'b1;
          resp_is_load <= 1'b1;
          resp_rd <= rd;
          resp_data <= mem_rvalid ? ld : 32'd0;
          resp_err <= !mem_rvalid;
          err_cause <= mem_rvalid ? 2'b00 : 2'b11;
          err_addr <= mem_rvalid ? 32'd0 : a;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
